jam_param: RTL and testbench
============================

Name: jam_param

Overview:
- Parametrised successor to the fixed 8x8 job-assignment machine.
- Exhaustively enumerates every assignment of N jobs to N workers, reading costs from an external cost ROM that has one cycle of latency.
- Reports the minimum total cost, the number of assignments that reach that minimum, and the lexicographically first optimal permutation.
- New in this generation: start/busy handshake, re-runnable without reset, optimal-permutation output, and a count that saturates instead of overflowing.

Parameters:
- N, 8: number of workers and jobs; legal range 2..8.
- COST_W, 7: width of one cost entry.
- IDX_W, 3: width of a worker/job index; must satisfy 2**IDX_W >= N.
- SUM_W, 10: width of the accumulated cost; must satisfy SUM_W >= COST_W + ceil(log2 N).
- CNT_W, 16: width of MatchCount; the count saturates at 2**CNT_W-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- Start  in  1  run request; accepted only in IDLE or DONE.
- Busy  out  1  high while the enumeration is running.
- W  out  IDX_W  worker index presented to the cost ROM.
- J  out  IDX_W  job index presented to the cost ROM.
- Cost  in  COST_W  ROM data for the W/J pair registered on the previous edge.
- MinCost  out  SUM_W  minimum total cost found.
- MatchCount  out  CNT_W  number of permutations whose total equals MinCost.
- BestPerm  out  N*IDX_W  job of worker w in bits [w*IDX_W +: IDX_W]; first optimal permutation in lexicographic order.
- Valid  out  1  results valid; held high in DONE.

Behaviour:
- Reset (RST=0 at an edge):
  - State goes to IDLE.
  - W, J, MinCost, MatchCount, Busy and Valid are all 0.
  - BestPerm is the identity (worker w holds job w).
  - Reset overrides everything, including mid-run; partial results are discarded.
- States: IDLE, FETCH, ACC, DONE.
- IDLE / DONE:
  - Start=1 at an edge loads perm = identity and clears sum and the run's result registers.
  - MinCost is set to all-ones, MatchCount to 0, Valid to 0, Busy to 1, fetch counter k to 0, and the state goes to FETCH.
  - In DONE, outputs hold until Start is accepted.
- FETCH (N cycles, k = 0..N-1):
  - W = k and J = perm[k], both registered outputs.
  - The Cost sampled in the cycle after W=k is added to sum.
  - Sum is cleared at entry, so the k=0 cost becomes the first addend.
  - After the cycle with k = N-1, the state goes to ACC.
- ACC (1 cycle):
  - Add the Cost for W=N-1 to form total, using zero-extended, non-wrapping arithmetic at SUM_W.
  - If total < MinCost: MinCost = total, MatchCount = 1, BestPerm = perm.
  - Else if total == MinCost: MatchCount increments, saturating at 2**CNT_W-1.
  - If perm is the last permutation (strictly descending): go to DONE, Busy=0, Valid=1.
  - Otherwise: perm = next lexicographic permutation, computed combinationally (find pivot, swap with its smallest larger successor, reverse the suffix); clear sum, set k=0, and go to FETCH.
- Timing:
  - Each permutation takes exactly N+1 cycles.
  - Valid rises exactly N!*(N+1) edges after the edge that accepted Start; for N=8 that is 362880 cycles.
- W and J only ever take values 0..N-1.
- W/J hold their last values in ACC and DONE.
- Start while Busy=1 is ignored, with no effect on the run.
- Ties: the first permutation reaching the minimum is retained in BestPerm; later equal totals only increment the count.
- Costs of 0 are legal; a zero total is handled like any other value.

Test Plan:
- N=8, all costs 5 -> MinCost=40, MatchCount=40320, BestPerm=identity, Valid at 362880 cycles after Start.
- N=8, C[w][j] = (w==j) ? 0 : 100 -> MinCost=0, MatchCount=1, BestPerm=identity.
- N=4, C[w][j] = w+j -> MinCost=12, MatchCount=24, Valid exactly 120 cycles after Start; check the W/J sequence of the first permutation is (0,0),(1,1),(2,2),(3,3).
- N=3, C = {{9,1,9},{9,9,1},{1,9,9}} -> MinCost=3, MatchCount=1, BestPerm = {1,2,0}; Start pulsed during the run is ignored and the result is unchanged.
- Reset mid-run: drive RST=0 at cycle 50 -> all outputs return to their reset values the next edge. Then rerun with Start -> same results as an uninterrupted run.
- Back-to-back runs: after Valid, load a new table and assert Start -> Valid drops the next edge and new results appear with no reset in between.
- CNT_W=4, N=4, all costs equal -> MatchCount saturates at 15.

Source files
------------

// File: rtl/jam_param.sv
// jam_param: exhaustive search of all N-job assignments against an external cost ROM
module jam_param #(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int IDX_W  = 3,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    output logic                 Busy,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    input  logic [COST_W-1:0]    Cost,
    output logic [SUM_W-1:0]     MinCost,
    output logic [CNT_W-1:0]     MatchCount,
    output logic [N*IDX_W-1:0]   BestPerm,
    output logic                 Valid
);
    typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;
    state_t state;
    logic [IDX_W-1:0] k, jk, pv;
    logic [IDX_W-1:0] perm [N];
    logic [IDX_W-1:0] nxt [N];
    logic [SUM_W-1:0] sum, total;
    logic [N*IDX_W-1:0] ident, perm_flat;
    logic last;
    int piv, suc, src;
    always_comb begin
        total = sum + SUM_W'(Cost);
        jk = perm[0];
        last = 1'b1;
        piv = 0;
        suc = 0;
        src = 0;
        pv = perm[0];
        ident = '0;
        perm_flat = '0;
        for (int i = 0; i < N; i++) begin
            ident[i*IDX_W +: IDX_W] = IDX_W'(i);
            perm_flat[i*IDX_W +: IDX_W] = perm[i];
            if (IDX_W'(i) == k) jk = perm[i];
        end
        // next lexicographic permutation: pivot, swap with smallest larger successor, reverse suffix
        for (int i = 0; i < N-1; i++) if (perm[i] < perm[i+1]) begin
            last = 1'b0;
            piv = i;
        end
        for (int i = 0; i < N; i++) if (i == piv) pv = perm[i];
        for (int i = 0; i < N; i++) if (i > piv && perm[i] > pv) suc = i;
        for (int i = 0; i < N; i++) begin
            src = i < piv ? i : i == piv ? suc : N + piv - i;
            nxt[i] = perm[0];
            for (int m = 0; m < N; m++) if (m == src) nxt[i] = perm[m];
            if (i > piv && src == suc) nxt[i] = pv;
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            k <= '0;
            sum <= '0;
            W <= '0;
            J <= '0;
            MinCost <= '0;
            MatchCount <= '0;
            BestPerm <= ident;
            Busy <= 1'b0;
            Valid <= 1'b0;
            for (int i = 0; i < N; i++) perm[i] <= IDX_W'(i);
        end else begin
            case (state)
                IDLE, DONE: if (Start) begin
                    for (int i = 0; i < N; i++) perm[i] <= IDX_W'(i);
                    sum <= '0;
                    MinCost <= '1;
                    MatchCount <= '0;
                    BestPerm <= ident;
                    Valid <= 1'b0;
                    Busy <= 1'b1;
                    k <= '0;
                    state <= FETCH;
                end
                FETCH: begin
                    W <= k;
                    J <= jk;
                    sum <= k == '0 ? '0 : total;
                    k <= k + 1'b1;
                    if (k == IDX_W'(N-1)) state <= ACC;
                end
                ACC: begin
                    if (total < MinCost) begin
                        MinCost <= total;
                        MatchCount <= CNT_W'(1);
                        BestPerm <= perm_flat;
                    end else if (total == MinCost && MatchCount != '1) begin
                        MatchCount <= MatchCount + 1'b1;
                    end
                    if (last) begin
                        state <= DONE;
                        Busy <= 1'b0;
                        Valid <= 1'b1;
                    end else begin
                        perm <= nxt;
                        sum <= '0;
                        k <= '0;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jam_param.sv
// tb_jam_param: vector table, random tables against an enumeration model, and corner sequences
module tb_jam_param;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start4 = 1'b0, busy4, valid4;
    logic [2:0] w4, j4;
    logic [6:0] cost4;
    logic [9:0] min4;
    logic [15:0] cnt4;
    logic [11:0] best4;

    logic start3 = 1'b0, busy3, valid3;
    logic [2:0] w3, j3;
    logic [6:0] cost3;
    logic [9:0] min3;
    logic [15:0] cnt3;
    logic [8:0] best3;

    logic start_s = 1'b0, busy_s, valid_s;
    logic [2:0] w_s, j_s;
    logic [9:0] min_s;
    logic [3:0] cnt_s;
    logic [11:0] best_s;

    int tbl4 [8][8];
    int tbl3 [8][8];
    assign cost4 = 7'(tbl4[w4][j4]);
    assign cost3 = 7'(tbl3[w3][j3]);

    jam_param #(.N(4)) u4 (.CLK(clk), .RST(rst_n), .Start(start4), .Busy(busy4), .W(w4), .J(j4),
        .Cost(cost4), .MinCost(min4), .MatchCount(cnt4), .BestPerm(best4), .Valid(valid4));
    jam_param #(.N(3)) u3 (.CLK(clk), .RST(rst_n), .Start(start3), .Busy(busy3), .W(w3), .J(j3),
        .Cost(cost3), .MinCost(min3), .MatchCount(cnt3), .BestPerm(best3), .Valid(valid3));
    jam_param #(.N(4), .CNT_W(4)) us (.CLK(clk), .RST(rst_n), .Start(start_s), .Busy(busy_s), .W(w_s), .J(j_s),
        .Cost(7'd7), .MinCost(min_s), .MatchCount(cnt_s), .BestPerm(best_s), .Valid(valid_s));

    typedef struct {
        int kind;
        int emin;
        int ecnt;
        logic [11:0] ebest;
    } vec_t;
    vec_t vecs [4];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // walk every 4-digit base-4 tuple in ascending order; keeping only permutations gives lex order
    task automatic model(output int mn, output int cnt, output logic [11:0] best);
        int d [4];
        int c, tot, used;
        bit ok;
        mn = 1 << 30;
        cnt = 0;
        best = '0;
        for (int code = 0; code < 256; code++) begin
            c = code;
            for (int w = 3; w >= 0; w--) begin
                d[w] = c % 4;
                c = c / 4;
            end
            used = 0;
            ok = 1'b1;
            tot = 0;
            for (int w = 0; w < 4; w++) begin
                if (used[d[w]]) ok = 1'b0;
                used[d[w]] = 1'b1;
                tot += tbl4[w][d[w]];
            end
            if (ok && tot < mn) begin
                mn = tot;
                cnt = 1;
                for (int w = 0; w < 4; w++) best[w*3 +: 3] = 3'(d[w]);
            end else if (ok && tot == mn) begin
                cnt++;
            end
        end
    endtask

    task automatic fill(input int kind, input int hi);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                tbl4[w][j] = kind == 0 ? 5 : kind == 1 ? (w == j ? 0 : 100) : kind == 2 ? w + j :
                             kind == 3 ? (j == (w + 1) % 4 ? 1 : 9) : int'($urandom_range(0, hi));
    endtask

    task automatic run4(output int cyc);
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        chk("busy_after_start", busy4, 1);
        chk("valid_drop_after_start", valid4, 0);
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cyc++;
            chk("first_perm_w", w4, k);
            chk("first_perm_j", j4, k);
        end
        while (!valid4 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("run_cycles", cyc, 120);
    endtask

    initial begin
        int cyc, mn, cnt;
        logic [11:0] best;
        vecs[0] = '{0, 20, 24, 12'h688};
        vecs[1] = '{1, 0, 1, 12'h688};
        vecs[2] = '{2, 12, 24, 12'h688};
        vecs[3] = '{3, 4, 1, 12'h0D1};
        fill(0, 0);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) tbl3[w][j] = j == (w + 1) % 3 ? 1 : 9;
        repeat (3) @(negedge clk);
        chk("reset_w", w4, 0);
        chk("reset_j", j4, 0);
        chk("reset_min", min4, 0);
        chk("reset_cnt", cnt4, 0);
        chk("reset_busy", busy4, 0);
        chk("reset_valid", valid4, 0);
        chk("reset_best", best4, 12'h688);
        chk("reset_best3", best3, 9'h088);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            fill(vecs[i].kind, 0);
            run4(cyc);
            chk("vec_min", min4, vecs[i].emin);
            chk("vec_cnt", cnt4, vecs[i].ecnt);
            chk("vec_best", best4, vecs[i].ebest);
        end
        repeat (5) @(negedge clk);
        chk("done_hold_valid", valid4, 1);
        chk("done_hold_min", min4, 4);

        for (int r = 0; r < 6; r++) begin
            fill(4, r % 2 ? 3 : 127);
            model(mn, cnt, best);
            run4(cyc);
            chk("rand_min", min4, mn);
            chk("rand_cnt", cnt4, cnt);
            chk("rand_best", best4, best);
        end

        fill(3, 0);
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_w", w4, 0);
        chk("midrst_j", j4, 0);
        chk("midrst_min", min4, 0);
        chk("midrst_cnt", cnt4, 0);
        chk("midrst_busy", busy4, 0);
        chk("midrst_valid", valid4, 0);
        chk("midrst_best", best4, 12'h688);
        rst_n = 1'b1;
        run4(cyc);
        chk("rerun_min", min4, 4);
        chk("rerun_cnt", cnt4, 1);
        chk("rerun_best", best4, 12'h0D1);

        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        cyc = 0;
        repeat (10) begin
            @(negedge clk);
            cyc++;
        end
        start3 = 1'b1;
        @(negedge clk);
        cyc++;
        start3 = 1'b0;
        while (!valid3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("n3_cycles", cyc, 24);
        chk("n3_min", min3, 3);
        chk("n3_cnt", cnt3, 1);
        chk("n3_best", best3, 9'h011);

        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        cyc = 0;
        while (!valid_s && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("sat_cycles", cyc, 120);
        chk("sat_cnt", cnt_s, 15);
        chk("sat_min", min_s, 28);
        chk("sat_best", best_s, 12'h688);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
